// File: rtl/ddr_app_arbiter.sv
// Two-port arbiter sharing one MIG 7-series UI app_* port; read data is routed back through a tag FIFO.
// Build option: define DDR_ARB_FIXED_PRIO_EN for fixed p0 priority (default is round robin).
module ddr_app_arbiter #(
    parameter int ADDR_WIDTH     = 28,
    parameter int APP_DATA_WIDTH = 128,
    parameter int MASK_WIDTH     = 16,
    parameter int RD_TAG_DEPTH   = 8
) (
    input  logic                      ui_clk,
    input  logic                      ui_clk_sync_rst,

    input  logic                      p0_req_valid,
    output logic                      p0_req_ready,
    input  logic                      p0_req_rd,
    input  logic [ADDR_WIDTH-1:0]     p0_req_addr,
    input  logic [APP_DATA_WIDTH-1:0] p0_req_wdata,
    output logic                      p0_rd_valid,
    output logic [APP_DATA_WIDTH-1:0] p0_rd_data,

    input  logic                      p1_req_valid,
    output logic                      p1_req_ready,
    input  logic                      p1_req_rd,
    input  logic [ADDR_WIDTH-1:0]     p1_req_addr,
    input  logic [APP_DATA_WIDTH-1:0] p1_req_wdata,
    output logic                      p1_rd_valid,
    output logic [APP_DATA_WIDTH-1:0] p1_rd_data,

    output logic [ADDR_WIDTH-1:0]     app_addr,
    output logic [2:0]                app_cmd,
    output logic                      app_en,
    output logic [APP_DATA_WIDTH-1:0] app_wdf_data,
    output logic                      app_wdf_end,
    output logic                      app_wdf_wren,
    output logic [MASK_WIDTH-1:0]     app_wdf_mask,
    input  logic                      app_rdy,
    input  logic                      app_wdf_rdy,
    input  logic [APP_DATA_WIDTH-1:0] app_rd_data,
    input  logic                      app_rd_data_valid,
    input  logic                      app_rd_data_end,

    output logic                      busy,
    output logic                      rd_underflow
);

    localparam int PW = (RD_TAG_DEPTH > 1) ? $clog2(RD_TAG_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(RD_TAG_DEPTH);

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    typedef struct packed {
        logic                      port;
        logic                      rd;
        logic [ADDR_WIDTH-1:0]     addr;
        logic [APP_DATA_WIDTH-1:0] wdata;
    } req_t;

    state_t                    state_q, state_d;
    logic                      port_q;
    logic                      app_en_q, app_en_d;
    logic                      wren_q, wren_d;
    logic [2:0]                cmd_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [APP_DATA_WIDTH-1:0] wdata_q;
    logic                      p0_ready_q, p1_ready_q;
    logic                      p0_rd_valid_q, p1_rd_valid_q;
    logic [APP_DATA_WIDTH-1:0] p0_rd_data_q, p1_rd_data_q;
    logic                      busy_q, busy_d;
    logic                      underflow_q;

    logic [RD_TAG_DEPTH-1:0]   tag_q;
    logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]             cnt_q, cnt_d;

    logic                      elig0, elig1, grant0, grant1;
    logic                      push, pop, head;
    req_t                      win;

`ifndef DDR_ARB_FIXED_PRIO_EN
    // Port preferred on the next contended grant; flips to the loser on every grant.
    logic                      prio_q;
`endif

    always_comb begin
        elig0  = p0_req_valid && (!p0_req_rd || (cnt_q != FULL_CNT));
        elig1  = p1_req_valid && (!p1_req_rd || (cnt_q != FULL_CNT));
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == S_IDLE) begin
`ifdef DDR_ARB_FIXED_PRIO_EN
            grant0 = elig0;
            grant1 = elig1 && !elig0;
`else
            grant1 = elig1 && (!elig0 || prio_q);
            grant0 = elig0 && !grant1;
`endif
        end

        win.port  = grant1;
        win.rd    = grant1 ? p1_req_rd    : p0_req_rd;
        win.addr  = grant1 ? p1_req_addr  : p0_req_addr;
        win.wdata = grant1 ? p1_req_wdata : p0_req_wdata;

        // A read tag is pushed only when the MIG takes the command.
        push = app_en_q && app_rdy && cmd_q[0];
        pop  = app_rd_data_valid && (cnt_q != '0);
        head = tag_q[rd_ptr_q];

        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + CW'(1);
        else if (pop && !push)
            cnt_d = cnt_q - CW'(1);

        app_en_d = app_en_q && !app_rdy;
        wren_d   = wren_q && !app_wdf_rdy;
        state_d  = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant0 || grant1) begin
                    app_en_d = 1'b1;
                    wren_d   = !win.rd;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!app_en_d && !wren_d)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE) || (cnt_d != '0);
    end

    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            state_q       <= S_IDLE;
            port_q        <= 1'b0;
            app_en_q      <= 1'b0;
            wren_q        <= 1'b0;
            cmd_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            p0_ready_q    <= 1'b0;
            p1_ready_q    <= 1'b0;
            p0_rd_valid_q <= 1'b0;
            p1_rd_valid_q <= 1'b0;
            p0_rd_data_q  <= '0;
            p1_rd_data_q  <= '0;
            busy_q        <= 1'b0;
            underflow_q   <= 1'b0;
            tag_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
`ifndef DDR_ARB_FIXED_PRIO_EN
            prio_q        <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            app_en_q   <= app_en_d;
            wren_q     <= wren_d;
            p0_ready_q <= grant0;
            p1_ready_q <= grant1;

            if (grant0 || grant1) begin
                port_q  <= win.port;
                cmd_q   <= {2'b00, win.rd};
                addr_q  <= win.addr;
                wdata_q <= win.wdata;
`ifndef DDR_ARB_FIXED_PRIO_EN
                prio_q  <= grant0;
`endif
            end

            if (push) begin
                tag_q[wr_ptr_q] <= port_q;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_d;

            p0_rd_valid_q <= pop && !head;
            p1_rd_valid_q <= pop && head;
            if (pop && !head)
                p0_rd_data_q <= app_rd_data;
            if (pop && head)
                p1_rd_data_q <= app_rd_data;

            if (app_rd_data_valid && (cnt_q == '0))
                underflow_q <= 1'b1;

            busy_q <= busy_d;
        end
    end

    // Single-beat commands: the end-of-burst marker carries no information.
    logic unused_rd_end;
    assign unused_rd_end = app_rd_data_end;

    assign p0_req_ready = p0_ready_q;
    assign p1_req_ready = p1_ready_q;
    assign p0_rd_valid  = p0_rd_valid_q;
    assign p1_rd_valid  = p1_rd_valid_q;
    assign p0_rd_data   = p0_rd_data_q;
    assign p1_rd_data   = p1_rd_data_q;
    assign app_addr     = addr_q;
    assign app_cmd      = cmd_q;
    assign app_en       = app_en_q;
    assign app_wdf_data = wdata_q;
    assign app_wdf_wren = wren_q;
    assign app_wdf_end  = wren_q;
    assign app_wdf_mask = '0;
    assign busy         = busy_q;
    assign rd_underflow = underflow_q;

endmodule

// File: tb/tb_ddr_app_arbiter.sv
// Self-checking bench for ddr_app_arbiter: vector table for single commands plus
// hand-written contention, read-routing, tag-full, reset and underflow sequences.
module tb_ddr_app_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam int MW = 16;

    logic ui_clk = 1'b0;
    logic rst    = 1'b1;
    always #5 ui_clk = ~ui_clk;

    logic          p0_req_valid = 0, p0_req_ready, p0_req_rd = 0;
    logic [AW-1:0] p0_req_addr = '0;
    logic [DW-1:0] p0_req_wdata = '0;
    logic          p0_rd_valid;
    logic [DW-1:0] p0_rd_data;
    logic          p1_req_valid = 0, p1_req_ready, p1_req_rd = 0;
    logic [AW-1:0] p1_req_addr = '0;
    logic [DW-1:0] p1_req_wdata = '0;
    logic          p1_rd_valid;
    logic [DW-1:0] p1_rd_data;
    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;
    logic          app_en, app_wdf_end, app_wdf_wren;
    logic [DW-1:0] app_wdf_data;
    logic [MW-1:0] app_wdf_mask;
    logic          app_rdy = 0, app_wdf_rdy = 0;
    logic [DW-1:0] app_rd_data = '0;
    logic          app_rd_data_valid = 0, app_rd_data_end = 0;
    logic          busy, rd_underflow;

    ddr_app_arbiter dut (
        .ui_clk(ui_clk), .ui_clk_sync_rst(rst),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_rd(p0_req_rd),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
        .p0_rd_valid(p0_rd_valid), .p0_rd_data(p0_rd_data),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_rd(p1_req_rd),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
        .p1_rd_valid(p1_rd_valid), .p1_rd_data(p1_rd_data),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end), .app_wdf_wren(app_wdf_wren),
        .app_wdf_mask(app_wdf_mask), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_end),
        .busy(busy), .rd_underflow(rd_underflow)
    );

    int nchecks = 0;
    int nerrors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: bench-side tag order plus expected {port, data} for each return.
    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } rd_exp_t;
    logic    exp_tag_q[$];
    rd_exp_t sb_q[$];
    rd_exp_t mon_e;

    always @(negedge ui_clk) begin
        if (!rst && (p0_rd_valid || p1_rd_valid)) begin
            if ((p0_rd_valid && p1_rd_valid) || (sb_q.size() == 0)) begin
                nchecks++;
                nerrors++;
                $display("FAIL rd_strobe: p0_rd_valid=%0b p1_rd_valid=%0b pending=%0d, expected one strobe for a pending read",
                         p0_rd_valid, p1_rd_valid, sb_q.size());
            end else begin
                mon_e = sb_q.pop_front();
                chk("rd_port", {127'b0, p1_rd_valid}, {127'b0, mon_e.port});
                chk("rd_data", mon_e.port ? p1_rd_data : p0_rd_data, mon_e.data);
            end
        end
    end

    function automatic logic ready_of(input logic p);
        return p ? p1_req_ready : p0_req_ready;
    endfunction

    task automatic set_req(input logic p, input logic v, input logic rd,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p) begin
            p1_req_valid = v; p1_req_rd = rd; p1_req_addr = a; p1_req_wdata = d;
        end else begin
            p0_req_valid = v; p0_req_rd = rd; p0_req_addr = a; p0_req_wdata = d;
        end
    endtask

    // All tasks start and end at posedge+1.
    task automatic issue_req(input logic p, input logic rd, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
        int waited = 0;
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        set_req(p, 1'b1, rd, a, d);
        while (waited < 20) begin
            @(posedge ui_clk); #1;
            waited++;
            if (ready_of(p)) break;
        end
        chk($sformatf("issue_grant_p%0d", p), {127'b0, ready_of(p)}, 1);
        set_req(p, 1'b0, rd, a, d);
        @(posedge ui_clk); #1;
        if (rd) exp_tag_q.push_back(p);
    endtask

    task automatic ret_data(input logic [DW-1:0] d);
        rd_exp_t e;
        if (exp_tag_q.size() == 0) begin
            nchecks++;
            nerrors++;
            $display("FAIL ret_data: bench has no outstanding read for data %0h", d);
        end else begin
            e.port = exp_tag_q.pop_front();
            e.data = d;
            sb_q.push_back(e);
        end
        app_rd_data = d;
        app_rd_data_valid = 1'b1;
        @(posedge ui_clk); #1;
        app_rd_data_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        p0_req_valid = 0;
        p1_req_valid = 0;
        app_rd_data_valid = 0;
        repeat (2) @(posedge ui_clk);
        #1 rst = 1'b0;
        exp_tag_q.delete();
        sb_q.delete();
    endtask

    typedef struct {
        logic          port;
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            rdy_dly;
        int            wdf_dly;
        logic [2:0]    exp_cmd;
        int            exp_en;
        int            exp_wren;
    } vec_t;
    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input int idx);
        int grants = 0, other = 0, en_n = 0, wr_n = 0, end_n = 0, lat = -1;
        logic [AW-1:0] a_seen = '0;
        logic [2:0]    c_seen = '0;
        logic [DW-1:0] d_seen = '0;
        app_rdy = (v.rdy_dly == 0);
        app_wdf_rdy = (v.wdf_dly == 0);
        set_req(v.port, 1'b1, v.rd, v.addr, v.wdata);
        for (int c = 1; c <= 16; c++) begin
            @(posedge ui_clk); #1;
            if (ready_of(v.port)) begin
                grants++;
                set_req(v.port, 1'b0, v.rd, v.addr, v.wdata);
            end
            if (ready_of(!v.port)) other++;
            if (app_en) begin
                if (en_n == 0) begin
                    lat = c; a_seen = app_addr; c_seen = app_cmd;
                end
                en_n++;
            end
            if (app_wdf_wren) begin
                if (wr_n == 0) d_seen = app_wdf_data;
                wr_n++;
                if (app_wdf_end) end_n++;
            end
            app_rdy = (en_n > v.rdy_dly);
            app_wdf_rdy = (wr_n > v.wdf_dly);
        end
        chk($sformatf("v%0d_grants", idx), grants, 1);
        chk($sformatf("v%0d_other_port_ready", idx), other, 0);
        chk($sformatf("v%0d_en_latency", idx), lat, 1);
        chk($sformatf("v%0d_en_cycles", idx), en_n, v.exp_en);
        chk($sformatf("v%0d_wren_cycles", idx), wr_n, v.exp_wren);
        chk($sformatf("v%0d_end_cycles", idx), end_n, v.exp_wren);
        chk($sformatf("v%0d_addr", idx), a_seen, v.addr);
        chk($sformatf("v%0d_cmd", idx), c_seen, v.exp_cmd);
        if (!v.rd) chk($sformatf("v%0d_wdata", idx), d_seen, v.wdata);
        if (v.rd) exp_tag_q.push_back(v.port);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, g1, ng, last_c;
        logic gport[8];

        vecs[0] = '{1'b0, 1'b0, 28'h0000010, 128'h55AA_55AA_0123_4567_89AB_CDEF_FEDC_3210, 0, 0, 3'b000, 1, 1};
        vecs[1] = '{1'b0, 1'b0, 28'h0000020, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 0, 3, 3'b000, 1, 4};
        vecs[2] = '{1'b1, 1'b0, 28'h0ABCDEF, 128'hCAFE_F00D_0000_0000_0000_0000_BEEF_0001, 2, 0, 3'b000, 3, 1};
        vecs[3] = '{1'b1, 1'b1, 28'h0000100, 128'h0, 0, 0, 3'b001, 1, 0};
        vecs[4] = '{1'b0, 1'b1, 28'hFFFFFFF, 128'h0, 3, 0, 3'b001, 4, 0};
        vecs[5] = '{1'b1, 1'b0, 28'h5555555, 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0, 1, 1, 3'b000, 2, 2};

        repeat (3) @(posedge ui_clk);
        #1;
        chk("rst_ctrl", {app_en, app_wdf_wren, app_wdf_end, p0_req_ready, p1_req_ready,
                         p0_rd_valid, p1_rd_valid, busy, rd_underflow}, 0);
        chk("rst_addr_cmd", {app_addr, app_cmd}, 0);
        chk("rst_rd_data", p0_rd_data | p1_rd_data, 0);
        chk("rst_wdf_data", app_wdf_data, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
        chk("mask_zero", app_wdf_mask, 0);
        chk("busy_reads_outstanding", busy, 1);
        ret_data(128'hD0D0_0001_0000_0000_0000_0000_0000_0003);
        ret_data(128'hD0D0_0002_0000_0000_0000_0000_0000_0004);
        @(posedge ui_clk); #1;
        chk("busy_idle_after_drain", busy, 0);

        // Both ports requesting continuously.
        do_reset();
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, 28'h0000001, 128'h1);
        set_req(1'b1, 1'b1, 1'b0, 28'h0000002, 128'h2);
        ng = 0;
        last_c = 0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge ui_clk); #1;
            if (p0_req_ready && p1_req_ready)
                chk("cont_dual_ready", 1, 0);
            else if ((p0_req_ready || p1_req_ready) && ng < 8) begin
                gport[ng] = p1_req_ready;
                ng++;
                last_c = c;
            end
        end
        p0_req_valid = 0;
        p1_req_valid = 0;
        chk("cont_grant_count", ng, 8);
        chk("cont_last_grant_cycle", last_c, 15);
        for (int k = 0; k < 8; k++) begin
`ifdef DDR_ARB_FIXED_PRIO_EN
            chk($sformatf("cont_grant%0d_port", k), {127'b0, gport[k]}, 0);
`else
            chk($sformatf("cont_grant%0d_port", k), {127'b0, gport[k]}, k % 2);
`endif
        end
        @(posedge ui_clk); #1;

        // In-order read routing.
        issue_req(1'b0, 1'b1, 28'h000A000, '0);
        issue_req(1'b1, 1'b1, 28'h000B000, '0);
        issue_req(1'b0, 1'b1, 28'h000C000, '0);
        ret_data(128'hD1D1_D1D1_0000_0000_0000_0000_1111_1111);
        ret_data(128'hD2D2_D2D2_0000_0000_0000_0000_2222_2222);
        ret_data(128'hD3D3_D3D3_0000_0000_0000_0000_3333_3333);
        @(posedge ui_clk); #1;

        // Tag FIFO full: reads stall, writes still go.
        for (int k = 0; k < 8; k++) issue_req(k[0], 1'b1, AW'(28'h0100000 + k), '0);
        chk("full_busy", busy, 1);
        set_req(1'b1, 1'b1, 1'b1, 28'h0BEEF00, '0);
        set_req(1'b0, 1'b1, 1'b0, 28'h0CAFE00, 128'hDEAD_BEEF);
        g0 = 0;
        g1 = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge ui_clk); #1;
            if (p0_req_ready) begin g0++; p0_req_valid = 0; end
            if (p1_req_ready) g1++;
        end
        chk("full_write_granted", g0, 1);
        chk("full_read_held", g1, 0);
        ret_data(128'hF000);
        g1 = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge ui_clk); #1;
            if (p1_req_ready) begin g1++; p1_req_valid = 0; end
        end
        chk("full_read_after_pop", g1, 1);
        exp_tag_q.push_back(1'b1);
        for (int k = 1; k <= 8; k++) ret_data(DW'(128'hF000 + k));
        @(posedge ui_clk); #1;
        chk("scoreboard_empty", sb_q.size(), 0);
        chk("tags_empty", exp_tag_q.size(), 0);
        chk("busy_after_full_drain", busy, 0);

        // Asynchronous reset during ISSUE.
        app_rdy = 1'b0;
        app_wdf_rdy = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 28'h0000777, 128'h777);
        @(posedge ui_clk); #1;
        p0_req_valid = 0;
        chk("midissue_en_before_rst", {app_en, app_wdf_wren}, 2'b11);
        #2 rst = 1'b1;
        #1;
        chk("midissue_en_after_rst", {app_en, app_wdf_wren, app_wdf_end, busy}, 0);
        repeat (2) @(posedge ui_clk);
        #1 rst = 1'b0;

        // Read data with nothing outstanding.
        do_reset();
        chk("uf_clear_after_reset", rd_underflow, 0);
        app_rd_data = 128'hBAD;
        app_rd_data_valid = 1'b1;
        @(posedge ui_clk); #1;
        app_rd_data_valid = 1'b0;
        chk("uf_set", rd_underflow, 1);
        chk("uf_no_strobe", {p0_rd_valid, p1_rd_valid}, 0);
        repeat (4) @(posedge ui_clk);
        #1;
        chk("uf_sticky", rd_underflow, 1);
        chk("uf_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
